// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state and mode definitions for the serial add/subtract unit
package serial_sub_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;
endpackage

// File: rtl/digit_sub_cell.sv
// rtl/digit_sub_cell.sv - combinational ripple of DIGIT one-bit subtract/add cells
module digit_sub_cell
   import serial_sub_pkg::*;
#(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   input  logic             mode,
   output logic [DIGIT-1:0] s,
   output logic             cout
);
   always_comb begin
      logic carry;
      carry = cin;
      s     = '0;
      for (int i = 0; i < DIGIT; i++) begin
         s[i] = a[i] ^ b[i] ^ carry;
         // A borrow cell is a carry cell with the minuend bit inverted.
         if (mode == MODE_ADD) begin
            carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
         end else begin
            carry = (~a[i] & b[i]) | (~a[i] & carry) | (b[i] & carry);
         end
      end
      cout = carry;
   end
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial add/subtract unit with valid/ready handshakes and flags
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V,
   output logic             Z
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [WIDTH-1:0] a_sh, b_sh, s_r, s_next;
   logic            carry, mode_r, a_msb, b_msb;
   logic            cout_r, v_r, z_r;
   logic [DIGIT-1:0] cell_s;
   logic            cell_cout;
   logic            last;
   logic            v_next;

   digit_sub_cell #(.DIGIT(DIGIT)) u_cell (
      .a    (a_sh[DIGIT-1:0]),
      .b    (b_sh[DIGIT-1:0]),
      .cin  (carry),
      .mode (mode_r),
      .s    (cell_s),
      .cout (cell_cout)
   );

   // Result digits enter at the top and drift down, landing in place after N shifts.
   assign s_next = (s_r >> DIGIT) | (WIDTH'(cell_s) << (WIDTH - DIGIT));
   assign last   = (cnt == CW'(N - 1));
   assign v_next = (mode_r == MODE_ADD)
                 ? ((a_msb == b_msb) && (s_next[WIDTH-1] != a_msb))
                 : ((a_msb != b_msb) && (s_next[WIDTH-1] != a_msb));

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         s_r    <= '0;
         carry  <= 1'b0;
         mode_r <= MODE_SUB;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         cout_r <= 1'b0;
         v_r    <= 1'b0;
         z_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh   <= A;
                  b_sh   <= B;
                  a_msb  <= A[WIDTH-1];
                  b_msb  <= B[WIDTH-1];
                  carry  <= Cin;
                  mode_r <= Mode;
                  s_r    <= '0;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               s_r   <= s_next;
               carry <= cell_cout;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  cout_r <= cell_cout;
                  v_r    <= v_next;
                  z_r    <= (s_next == '0);
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign S         = s_r;
   assign Cout      = cout_r;
   assign V         = v_r;
   assign Z         = z_r;
endmodule
